// File: rtl/sap_pkg.sv
// sap_pkg: shared widths and the program-loader state encoding for the
// SAP computer. No ports; imported by program_loader and load_checksum.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DRAIN,
        DONE,
        ERR
    } load_state_e;

endpackage

// File: rtl/load_checksum.sv
// load_checksum: running modulo-2^DATA_W sum over the loader frame.
// Ports: clk, reg_clr (async reset), clr_i (zero the sum), add_i
// (accumulate data_i), data_i (frame byte), match_o (sum + data_i == 0).
module load_checksum
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic              clk,
    input  logic              reg_clr,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] total;

    // The checksum byte itself is presented on data_i while in CHK,
    // so the match looks at the sum including the current byte.
    assign total   = sum_q + data_i;
    assign match_o = (total == '0);

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = total;
        end
    end

    always_ff @(posedge clk or posedge reg_clr) begin
        if (reg_clr) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed byte frame into the 16x8 SAP
// program memory starting at address 0, holding the processor in clear.
// Ports: clk, reg_clr (async active-high reset), start (load pulse),
//   in_data/in_valid/in_ready (byte handshake), mem_addr/mem_data/mem_we
//   (memory write port, registered), proc_hold, busy, done, err.
// Build option: define LOADER_CHECKSUM_EN to expect a trailing checksum
//   byte (CHK state, load_checksum instance); otherwise DATA -> DRAIN.
module program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic              clk,
    input  logic              reg_clr,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              proc_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    load_state_e       state_q;
    load_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    logic              xfer;
    logic              len_bad;
    logic              last_word;
    logic [DATA_W:0]   len_ext;

    assign in_ready  = (state_q == LEN) || (state_q == DATA)
                    || (state_q == CHK);
    assign busy      = in_ready || (state_q == DRAIN);
    assign proc_hold = busy || (state_q == ERR);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_data  = wdata_q;

    assign xfer      = in_valid && in_ready;
    assign len_ext   = {1'b0, in_data};
    assign len_bad   = len_ext > (DATA_W+1)'(DEPTH);
    assign last_word = (cnt_q == CNT_W'(1));

`ifdef LOADER_CHECKSUM_EN
    logic sum_ok;
    logic sum_clr;
    logic sum_add;

    // Clear only when start is honoured, so a stray start mid-load
    // cannot corrupt the running sum.
    assign sum_clr = start && ((state_q == IDLE) || (state_q == DONE)
                            || (state_q == ERR));
    assign sum_add = xfer && ((state_q == LEN) || (state_q == DATA));

    load_checksum #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk     (clk),
        .reg_clr (reg_clr),
        .clr_i   (sum_clr),
        .add_i   (sum_add),
        .data_i  (in_data),
        .match_o (sum_ok)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        addr_d  = '0;
                        // A zero length byte means a full memory image.
                        cnt_d   = (in_data == '0) ? CNT_W'(DEPTH)
                                                  : in_data[CNT_W-1:0];
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        // Held on the last word so the address never wraps.
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = sum_ok ? DRAIN : ERR;
                end
            end
`endif
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reg_clr) begin
        if (reg_clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames against a frame-level model of the
// loader, a scoreboard of expected memory writes and a bench memory.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reg_clr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       proc_hold;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    program_loader dut (
        .clk       (clk),
        .reg_clr   (reg_clr),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .proc_hold (proc_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [7:0]  pmem [16];
    logic [7:0]  exp_mem [16];
    logic        fill = 1'b0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_e;
    int          wr_cyc [$];

    // Bench program memory: captures on the edge after mem_we is seen.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill) begin
            for (int i = 0; i < 16; i++) pmem[i] <= 8'hA0 + 8'(i);
        end else if (mem_we) begin
            pmem[mem_addr] <= mem_data;
        end
    end

    // Compare process: every write against the scoreboard, and the
    // status outputs against their defining relations, every cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stray_write: got addr %0h data %02h, required no write",
                         mem_addr, mem_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== exp_e) begin
                    miscompares++;
                    $display("FAIL write: got addr %0h data %02h, required addr %0h data %02h",
                             mem_addr, mem_data, exp_e[11:8], exp_e[7:0]);
                end
            end
        end
        vectors++;
        if (proc_hold !== (busy | err) || (in_ready & ~busy) === 1'b1
            || (done & (busy | err)) === 1'b1) begin
            miscompares++;
            $display("FAIL status: got rdy %b busy %b hold %b done %b err %b",
                     in_ready, busy, proc_hold, done, err);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mem[%0d]", i), 32'(pmem[i]), 32'(exp_mem[i]));
        end
    endtask

    // Frame-level model: which words get written and whether it ends in done.
    task automatic expect_frame(input logic [7:0] fr[$], output bit ok);
        int n;
        ok = 1'b0;
        if (fr[0] > 8'd16) return;
        n = (fr[0] == 8'd0) ? 16 : int'(fr[0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'(i), fr[i+1]});
            exp_mem[i] = fr[i+1];
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 0; i <= n + 1; i++) s = s + fr[i];
            ok = (s == 8'h00);
        end
`else
        ok = 1'b1;
`endif
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_flags", 32'({done, err}), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got in_ready 0 for byte %02h, required 1", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap);
        bit ok;
        expect_frame(fr, ok);
        wr_cyc.delete();
        do_start();
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (i != fr.size() - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (ok) begin
            chk("drain_state", 32'({busy, done}), 32'h2);
            @(posedge clk); #1;
            chk("done_state", 32'({done, err, busy, proc_hold}), 32'h8);
        end else begin
            chk("err_state", 32'({done, err, busy, proc_hold, in_ready}), 32'h0A);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("end_flags", 32'({done, err, proc_hold}), ok ? 32'h4 : 32'h3);
        chk("write_q_empty", 32'(exp_q.size()), 0);
        check_mem();
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input int gap);
        logic [7:0] f [$];
        f = fr;
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            foreach (f[i]) s = s + f[i];
            if (f[0] <= 8'd16) f.push_back(8'h00 - s);
        end
`endif
        send_frame(f, gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] f [$];
        #1;
        reg_clr = 1'b1;
        fill = 1'b1;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hA0 + 8'(i);
        #1;
        chk("reset_outputs", 32'({in_ready, mem_we, proc_hold, busy,
            done, err, mem_addr, mem_data}), 0);
        @(posedge clk); #1;
        fill = 1'b0;
        reg_clr = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", 32'({in_ready, mem_we, proc_hold, busy,
            done, err, mem_addr, mem_data}), 0);

        // Three-word back-to-back frame.
        f = '{8'h03, 8'h1E, 8'h2F, 8'hE0};
        run_frame(f, 0);
        chk("t1_wr_count", 32'(wr_cyc.size()), 3);
        if (wr_cyc.size() == 3) begin
            chk("t1_wr_consec", 32'(wr_cyc[2] - wr_cyc[0]), 2);
        end
        chk("t1_mem0", 32'(pmem[0]), 32'h1E);
        chk("t1_mem1", 32'(pmem[1]), 32'h2F);
        chk("t1_mem2", 32'(pmem[2]), 32'hE0);
        chk("t1_mem3", 32'(pmem[3]), 32'hA3);

        // Length zero: full 16-word image.
        f.delete();
        f.push_back(8'h00);
        for (int i = 0; i < 16; i++) f.push_back(8'(i));
        run_frame(f, 0);
        chk("t2_wr_count", 32'(wr_cyc.size()), 16);
        chk("t2_mem0", 32'(pmem[0]), 32'h00);
        chk("t2_mem15", 32'(pmem[15]), 32'h0F);

        // Length 17: rejected after the length byte.
        f = '{8'h11};
        run_frame(f, 0);
        chk("t3_no_write", 32'(wr_cyc.size()), 0);
        chk("t3_err_hold", 32'({err, proc_hold}), 32'h3);

        // in_valid toggling mid-frame.
        f = '{8'h04, 8'h5A, 8'hC3, 8'h3C, 8'hA5};
        run_frame(f, 1);
        chk("t4_wr_count", 32'(wr_cyc.size()), 4);
        if (wr_cyc.size() == 4) begin
            chk("t4_wr_spacing", 32'(wr_cyc[3] - wr_cyc[0]), 6);
        end
        chk("t4_mem1", 32'(pmem[1]), 32'hC3);
        chk("t4_mem3", 32'(pmem[3]), 32'hA5);

        // Reset after two of five data bytes.
        exp_q.push_back({4'd0, 8'h11});
        exp_q.push_back({4'd1, 8'h22});
        exp_mem[0] = 8'h11;
        exp_mem[1] = 8'h22;
        do_start();
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk); #1;
        reg_clr = 1'b1;
        #1;
        chk("t5_reset_outputs", 32'({in_ready, mem_we, proc_hold, busy,
            done, err, mem_addr, mem_data}), 0);
        @(posedge clk); #1;
        reg_clr = 1'b0;
        @(posedge clk); #1;
        chk("t5_q_empty", 32'(exp_q.size()), 0);
        chk("t5_mem1", 32'(pmem[1]), 32'h22);
        chk("t5_mem2", 32'(pmem[2]), 32'h3C);
        check_mem();
        f = '{8'h02, 8'hAA, 8'hBB};
        run_frame(f, 0);
        chk("t5_fresh_mem0", 32'(pmem[0]), 32'hAA);
        chk("t5_fresh_done", 32'(done), 1);

`ifdef LOADER_CHECKSUM_EN
        f = '{8'h02, 8'h10, 8'h20, 8'hCE};
        send_frame(f, 0);
        chk("t6_good_done", 32'({done, err}), 32'h2);
        f = '{8'h02, 8'h10, 8'h20, 8'hCF};
        send_frame(f, 0);
        chk("t6_bad_err", 32'({done, err}), 32'h1);
        chk("t6_mem0", 32'(pmem[0]), 32'h10);
        chk("t6_mem1", 32'(pmem[1]), 32'h20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
